// File: rtl/w_74hc32_tester.sv
// Exhaustive stimulus/check engine for a quad 2-input OR gate.
// Sweeps every {A,B} pair, settles, samples Y and compares with A|B.
module w_74hc32_tester #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Y,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [2*WIDTH:0] ERR_CNT,
  output logic [WIDTH-1:0] FAIL_A,
  output logic [WIDTH-1:0] FAIL_B,
  output logic [WIDTH-1:0] FAIL_Y
);

  localparam int VW = 2 * WIDTH;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    IDLE, DRIVE, CHECK, FIN, DONE_ST
  } state_t;

  state_t        state, nxt;
  logic [VW-1:0] v;
  logic [SW-1:0] scnt;
  logic          armed;
  logic          go;
  logic          last_settle;
  logic          last_vec;
  logic          mis;

  assign A = v[VW-1:WIDTH];
  assign B = v[WIDTH-1:0];

  // armed blocks a START seen on the first edge after reset release
  assign go          = START && armed &&
                       (state == IDLE || state == DONE_ST);
  assign last_settle = (scnt == SW'(SETTLE - 1));
  assign last_vec    = &v;
  assign mis         = (Y != (A | B));

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= nxt;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (go) nxt = DRIVE;
      DRIVE:   if (last_settle) nxt = CHECK;
      CHECK:   nxt = last_vec ? FIN : DRIVE;
      FIN:     nxt = DONE_ST;
      DONE_ST: if (go) nxt = DRIVE;
      default: nxt = IDLE;
    endcase
  end

  // vector/settle counters and result registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      armed   <= 1'b0;
      v       <= '0;
      scnt    <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      PASS    <= 1'b0;
      ERR_CNT <= '0;
      FAIL_A  <= '0;
      FAIL_B  <= '0;
      FAIL_Y  <= '0;
    end else begin
      armed <= 1'b1;
      if (go) begin
        v       <= '0;
        scnt    <= '0;
        BUSY    <= 1'b1;
        DONE    <= 1'b0;
        PASS    <= 1'b0;
        ERR_CNT <= '0;
        FAIL_A  <= '0;
        FAIL_B  <= '0;
        FAIL_Y  <= '0;
      end else begin
        unique case (state)
          DRIVE: begin
            scnt <= last_settle ? '0 : scnt + 1'b1;
          end
          CHECK: begin
            if (mis) begin
              ERR_CNT <= ERR_CNT + 1'b1;
              if (ERR_CNT == '0) begin
                FAIL_A <= A;
                FAIL_B <= B;
                FAIL_Y <= Y;
              end
            end
            if (last_vec) BUSY <= 1'b0;
            else          v    <= v + 1'b1;
          end
          FIN: begin
            DONE <= 1'b1;
            PASS <= (ERR_CNT == '0);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_w_74hc32_tester.sv
// Scoreboard bench for w_74hc32_tester.
// Runs a good gate, faulty gates, restart, reset and a SETTLE=1 build.
module tb_w_74hc32_tester;

  typedef struct {
    logic       pass;
    int         err;
    logic [3:0] fa;
    logic [3:0] fb;
    logic [3:0] fy;
    int         cyc;
  } exp_t;

  logic       clk = 0;
  logic       rst_n;
  logic       start0, start1;
  logic [3:0] a0, b0, y0, a1, b1, y1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [8:0] err0, err1;
  logic [3:0] fa0, fb0, fy0, fa1, fb1, fy1;
  int         mode;

  int   n_run = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  // gate models: 0 good OR, 1 bit2 stuck-at-0, 2 AND gate
  always_comb begin
    y0 = a0 | b0;
    if (mode == 1) y0 = (a0 | b0) & 4'b1011;
    else if (mode == 2) y0 = a0 & b0;
  end
  assign y1 = a1 | b1;

  w_74hc32_tester #(.WIDTH(4), .SETTLE(2)) dut0 (
    .CLK(clk), .RST_N(rst_n), .START(start0),
    .A(a0), .B(b0), .Y(y0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0),
    .ERR_CNT(err0),
    .FAIL_A(fa0), .FAIL_B(fb0), .FAIL_Y(fy0)
  );

  w_74hc32_tester #(.WIDTH(4), .SETTLE(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1),
    .A(a1), .B(b1), .Y(y1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1),
    .ERR_CNT(err1),
    .FAIL_A(fa1), .FAIL_B(fb1), .FAIL_Y(fy1)
  );

  function automatic void chk(string n, int act, int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endfunction

  // monitor for dut0: busy-cycle count and results on DONE rise
  int   bc0;
  logic done0_q, busy0_q;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bc0 = 0; done0_q = 0; busy0_q = 0;
    end else begin
      if (busy0 && !busy0_q) bc0 = 0;
      if (busy0) bc0++;
      if (done0 && !done0_q) begin
        if (q0.size() == 0) chk("d0_unexpected_done", 1, 0);
        else begin
          e = q0.pop_front();
          chk("d0_pass", pass0, e.pass);
          chk("d0_err", err0, e.err);
          chk("d0_fail_a", fa0, e.fa);
          chk("d0_fail_b", fb0, e.fb);
          chk("d0_fail_y", fy0, e.fy);
          chk("d0_busy_cycles", bc0, e.cyc);
        end
      end
      done0_q = done0; busy0_q = busy0;
    end
  end

  // monitor for dut1
  int   bc1;
  logic done1_q, busy1_q;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bc1 = 0; done1_q = 0; busy1_q = 0;
    end else begin
      if (busy1 && !busy1_q) bc1 = 0;
      if (busy1) bc1++;
      if (done1 && !done1_q) begin
        if (q1.size() == 0) chk("d1_unexpected_done", 1, 0);
        else begin
          e = q1.pop_front();
          chk("d1_pass", pass1, e.pass);
          chk("d1_err", err1, e.err);
          chk("d1_fail_a", fa1, e.fa);
          chk("d1_fail_b", fb1, e.fb);
          chk("d1_fail_y", fy1, e.fy);
          chk("d1_busy_cycles", bc1, e.cyc);
        end
      end
      done1_q = done1; busy1_q = busy1;
    end
  end

  task automatic zero0(string n);
    chk({n, "_busy"}, busy0, 0);
    chk({n, "_done"}, done0, 0);
    chk({n, "_pass"}, pass0, 0);
    chk({n, "_err"}, err0, 0);
    chk({n, "_a"}, a0, 0);
    chk({n, "_b"}, b0, 0);
    chk({n, "_fail"}, {fa0, fb0, fy0}, 0);
  endtask

  task automatic go0(exp_t e);
    start0 = 1;
    q0.push_back(e);
    @(negedge clk);
    start0 = 0;
  endtask

  task automatic wait0(string n);
    for (int i = 0; i < 1000 && !done0; i++) @(negedge clk);
    chk({n, "_done_seen"}, done0, 1);
  endtask

  task automatic wait1(string n);
    for (int i = 0; i < 1000 && !done1; i++) @(negedge clk);
    chk({n, "_done_seen"}, done1, 1);
  endtask

  initial begin
    rst_n = 0; start0 = 0; start1 = 0; mode = 0;
    repeat (3) @(negedge clk);
    zero0("reset");

    // START together with reset release is ignored
    rst_n = 1; start0 = 1;
    @(negedge clk);
    start0 = 0;
    chk("start_at_release_ignored", busy0, 0);
    repeat (3) @(negedge clk);

    // good gate
    go0('{1'b1, 0, 4'h0, 4'h0, 4'h0, 768});
    chk("busy_after_start", busy0, 1);
    wait0("good");

    // bit2 stuck-at-0: any vector with A[2]|B[2] fails -> 192
    mode = 1;
    go0('{1'b0, 192, 4'h0, 4'h4, 4'h0, 768});
    chk("restart_clears_done", done0, 0);
    wait0("stuck");
    chk("ab_hold_all_ones", {a0, b0}, 8'hff);

    // AND gate, extra START mid-run must be ignored
    mode = 2;
    go0('{1'b0, 240, 4'h0, 4'h1, 4'h0, 768});
    repeat (298) @(negedge clk);
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    wait0("and_gate");

    // reset mid-run, then a fresh full pass
    mode = 0;
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    repeat (399) @(negedge clk);
    rst_n = 0;
    #1;
    zero0("midrun_reset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    go0('{1'b1, 0, 4'h0, 4'h0, 4'h0, 768});
    wait0("after_reset");

    // SETTLE=1 build: vector advances every 2 cycles
    start1 = 1;
    q1.push_back('{1'b1, 0, 4'h0, 4'h0, 4'h0, 512});
    @(negedge clk);
    start1 = 0;
    chk("s1_b_t1", b1, 0);
    @(negedge clk);
    chk("s1_b_t2", b1, 0);
    @(negedge clk);
    chk("s1_b_t3", b1, 1);
    repeat (2) @(negedge clk);
    chk("s1_b_t5", b1, 2);
    wait1("s1_run1");

    // rerun from DONE_ST
    start1 = 1;
    q1.push_back('{1'b1, 0, 4'h0, 4'h0, 4'h0, 512});
    @(negedge clk);
    start1 = 0;
    chk("s1_rerun_done_clr", done1, 0);
    chk("s1_rerun_pass_clr", pass1, 0);
    wait1("s1_run2");

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
